// File: rtl/vga_layer_ctrl.sv
// Pixel source scheduler for vga_driver: selects a streamed window, a solid window
// or the background colour per request, with frame-synchronous shadow configuration.
module vga_layer_ctrl #(
  parameter int          CW           = 11,
  parameter logic [15:0] UF_COLOR_RST = 16'hF800
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          data_req,
  input  logic [CW-1:0] pixel_xpos,
  input  logic [CW-1:0] pixel_ypos,
  input  logic          vga_vs,
  output logic [15:0]   pixel_data,
  input  logic [15:0]   src_data,
  input  logic          src_valid,
  output logic          src_ready,
  output logic          src_sof,
  input  logic          cfg_wr,
  input  logic [3:0]    cfg_addr,
  input  logic [15:0]   cfg_wdata,
  output logic [15:0]   cfg_rdata,
  input  logic          cfg_commit
);

  typedef struct packed {
    logic [15:0]   bg_color;
    logic [CW-1:0] w0_x0;
    logic [CW-1:0] w0_y0;
    logic [CW-1:0] w0_x1;
    logic [CW-1:0] w0_y1;
    logic [15:0]   w0_color;
    logic [CW-1:0] w1_x0;
    logic [CW-1:0] w1_y0;
    logic [CW-1:0] w1_x1;
    logic [CW-1:0] w1_y1;
    logic          w1_en;
    logic          w0_en;
    logic [15:0]   uf_color;
  } cfg_t;

  cfg_t        stage;
  cfg_t        shadow;
  logic        vs_q;
  logic        boundary;
  logic        pending;
  logic        uf_sticky;
  logic [7:0]  frame_cnt;
  logic        in_w0;
  logic        in_w1;
  logic        underflow;

  // Half-open rectangle test; x1 <= x0 or y1 <= y0 naturally yields an empty window.
  function automatic logic in_window(
    input logic          en,
    input logic [CW-1:0] x0,
    input logic [CW-1:0] y0,
    input logic [CW-1:0] x1,
    input logic [CW-1:0] y1,
    input logic [CW-1:0] x,
    input logic [CW-1:0] y
  );
    return en && (x >= x0) && (x < x1) && (y >= y0) && (y < y1);
  endfunction

  always_comb begin
    boundary  = vs_q & ~vga_vs;
    in_w0     = in_window(shadow.w0_en, shadow.w0_x0, shadow.w0_y0,
                          shadow.w0_x1, shadow.w0_y1, pixel_xpos, pixel_ypos);
    in_w1     = in_window(shadow.w1_en, shadow.w1_x0, shadow.w1_y0,
                          shadow.w1_x1, shadow.w1_y1, pixel_xpos, pixel_ypos);
    src_ready = data_req & in_w1;
    underflow = src_ready & ~src_valid;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stage          <= '0;
      stage.uf_color <= UF_COLOR_RST;
    end else if (cfg_wr) begin
      case (cfg_addr)
        4'd0:  stage.bg_color <= cfg_wdata;
        4'd1:  stage.w0_x0    <= cfg_wdata[CW-1:0];
        4'd2:  stage.w0_y0    <= cfg_wdata[CW-1:0];
        4'd3:  stage.w0_x1    <= cfg_wdata[CW-1:0];
        4'd4:  stage.w0_y1    <= cfg_wdata[CW-1:0];
        4'd5:  stage.w0_color <= cfg_wdata;
        4'd6:  stage.w1_x0    <= cfg_wdata[CW-1:0];
        4'd7:  stage.w1_y0    <= cfg_wdata[CW-1:0];
        4'd8:  stage.w1_x1    <= cfg_wdata[CW-1:0];
        4'd9:  stage.w1_y1    <= cfg_wdata[CW-1:0];
        4'd10: begin
          stage.w0_en <= cfg_wdata[0];
          stage.w1_en <= cfg_wdata[1];
        end
        4'd11: stage.uf_color <= cfg_wdata;
        default: ;
      endcase
    end
  end

  // Shadow copy takes the staging value from before any write landing in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow          <= '0;
      shadow.uf_color <= UF_COLOR_RST;
    end else if (boundary && (pending || cfg_commit)) begin
      shadow <= stage;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_q      <= 1'b1;
      src_sof   <= 1'b0;
      frame_cnt <= 8'd0;
      pending   <= 1'b0;
    end else begin
      vs_q    <= vga_vs;
      src_sof <= boundary;
      if (boundary) begin
        frame_cnt <= frame_cnt + 8'd1;
        pending   <= 1'b0;
      end else if (cfg_commit) begin
        pending <= 1'b1;
      end
    end
  end

  // A fresh underflow outranks a simultaneous clear so the event is never lost.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      uf_sticky <= 1'b0;
    end else if (underflow) begin
      uf_sticky <= 1'b1;
    end else if (cfg_wr && (cfg_addr == 4'd15)) begin
      uf_sticky <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pixel_data <= 16'h0000;
    end else if (!data_req) begin
      pixel_data <= 16'h0000;
    end else if (in_w1) begin
      pixel_data <= src_valid ? src_data : shadow.uf_color;
    end else if (in_w0) begin
      pixel_data <= shadow.w0_color;
    end else begin
      pixel_data <= shadow.bg_color;
    end
  end

  always_comb begin
    cfg_rdata = 16'h0000;
    case (cfg_addr)
      4'd0:  cfg_rdata = stage.bg_color;
      4'd1:  cfg_rdata = 16'(stage.w0_x0);
      4'd2:  cfg_rdata = 16'(stage.w0_y0);
      4'd3:  cfg_rdata = 16'(stage.w0_x1);
      4'd4:  cfg_rdata = 16'(stage.w0_y1);
      4'd5:  cfg_rdata = stage.w0_color;
      4'd6:  cfg_rdata = 16'(stage.w1_x0);
      4'd7:  cfg_rdata = 16'(stage.w1_y0);
      4'd8:  cfg_rdata = 16'(stage.w1_x1);
      4'd9:  cfg_rdata = 16'(stage.w1_y1);
      4'd10: cfg_rdata = {14'b0, stage.w1_en, stage.w0_en};
      4'd11: cfg_rdata = stage.uf_color;
      4'd15: cfg_rdata = {uf_sticky, pending, 6'b0, frame_cnt};
      default: cfg_rdata = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_vga_layer_ctrl.sv
// Self-checking bench for vga_layer_ctrl: directed vectors, corner sequences and
// randomized traffic compared against a register-array reference model.
module tb_vga_layer_ctrl;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rstn;
  logic          data_req;
  logic [CW-1:0] pixel_xpos;
  logic [CW-1:0] pixel_ypos;
  logic          vga_vs;
  logic [15:0]   pixel_data;
  logic [15:0]   src_data;
  logic          src_valid;
  logic          src_ready;
  logic          src_sof;
  logic          cfg_wr;
  logic [3:0]    cfg_addr;
  logic [15:0]   cfg_wdata;
  logic [15:0]   cfg_rdata;
  logic          cfg_commit;

  vga_layer_ctrl #(.CW(CW), .UF_COLOR_RST(16'hF800)) dut (
    .clk(clk), .rstn(rstn), .data_req(data_req), .pixel_xpos(pixel_xpos),
    .pixel_ypos(pixel_ypos), .vga_vs(vga_vs), .pixel_data(pixel_data),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .src_sof(src_sof), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_commit(cfg_commit)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int sof_seen = 0;
  logic last_ready;

  // Reference model: register images as plain arrays indexed by address.
  logic [15:0] m_stage [16];
  logic [15:0] m_shad  [16];
  bit          m_vs_q;
  int          m_fc;
  bit          m_pend;
  bit          m_sticky;
  logic [15:0] m_pix;
  bit          m_sof;

  typedef struct {
    logic        req;
    int          x;
    int          y;
    logic [15:0] exp_pix;
    logic        exp_ready;
  } vec_t;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_stage[i] = 16'h0000;
      m_shad[i]  = 16'h0000;
    end
    m_stage[11] = 16'hF800;
    m_shad[11]  = 16'hF800;
    m_vs_q = 1; m_fc = 0; m_pend = 0; m_sticky = 0; m_pix = 16'h0000; m_sof = 0;
  endfunction

  function automatic bit m_in_win(input int n, input int x, input int y);
    int b;
    b = (n == 0) ? 1 : 6;
    return m_shad[10][n] && x >= int'(m_shad[b]) && x < int'(m_shad[b+2])
           && y >= int'(m_shad[b+1]) && y < int'(m_shad[b+3]);
  endfunction

  function automatic logic [15:0] m_read(input int a);
    if (a == 15) return {m_sticky, m_pend, 6'b0, 8'(m_fc)};
    if (a >= 12) return 16'h0000;
    return m_stage[a];
  endfunction

  function automatic logic [15:0] m_mask(input int a, input logic [15:0] d);
    if ((a >= 1 && a <= 4) || (a >= 6 && a <= 9)) return d & 16'h07FF;
    if (a == 10) return d & 16'h0003;
    return d;
  endfunction

  // One clock: check combinational outputs, advance model at the edge, check registered outputs.
  task automatic apply_stimulus();
    bit bnd, w0, w1, uf;
    int a;
    #1;
    w0 = m_in_win(0, int'(pixel_xpos), int'(pixel_ypos));
    w1 = m_in_win(1, int'(pixel_xpos), int'(pixel_ypos));
    last_ready = src_ready;
    check_output("src_ready", {31'b0, src_ready}, {31'b0, data_req && w1});
    check_output("cfg_rdata", {16'b0, cfg_rdata}, {16'b0, m_read(int'(cfg_addr))});
    @(posedge clk);
    uf = 0;
    if (!data_req) m_pix = 16'h0000;
    else if (w1) begin
      if (src_valid) m_pix = src_data;
      else begin m_pix = m_shad[11]; uf = 1; end
    end else if (w0) m_pix = m_shad[5];
    else m_pix = m_shad[0];
    a = int'(cfg_addr);
    if (cfg_wr && a == 15) m_sticky = 0;
    if (uf) m_sticky = 1;
    bnd = m_vs_q && !vga_vs;
    m_vs_q = vga_vs;
    m_sof = bnd;
    if (bnd) begin
      m_fc = (m_fc + 1) % 256;
      if (m_pend || cfg_commit) begin
        m_shad = m_stage;
        m_pend = 0;
      end
    end else if (cfg_commit) m_pend = 1;
    if (cfg_wr && a < 12) m_stage[a] = m_mask(a, cfg_wdata);
    #1;
    check_output("pixel_data", {16'b0, pixel_data}, {16'b0, m_pix});
    check_output("src_sof", {31'b0, src_sof}, {31'b0, m_sof});
    if (src_sof === 1'b1) sof_seen++;
  endtask

  task automatic set_idle();
    data_req = 0; src_valid = 0; cfg_wr = 0; cfg_commit = 0;
  endtask

  task automatic cfg_write(input int a, input logic [15:0] d);
    cfg_wr = 1; cfg_addr = 4'(a); cfg_wdata = d;
    apply_stimulus();
    cfg_wr = 0;
  endtask

  task automatic commit_pulse();
    cfg_commit = 1;
    apply_stimulus();
    cfg_commit = 0;
  endtask

  task automatic frame();
    vga_vs = 0;
    apply_stimulus();
    vga_vs = 1;
    apply_stimulus();
  endtask

  task automatic req_pixel(input int x, input int y, input logic valid, input logic [15:0] d);
    data_req = 1; pixel_xpos = CW'(x); pixel_ypos = CW'(y); src_valid = valid; src_data = d;
    apply_stimulus();
    data_req = 0; src_valid = 0;
  endtask

  task automatic read_check(input string name, input int a, input logic [15:0] exp);
    cfg_addr = 4'(a);
    #1;
    check_output(name, {16'b0, cfg_rdata}, {16'b0, exp});
  endtask

  initial begin
    vec_t vecs[7];
    int   cnt;
    int   sof_base;
    logic [15:0] sdata;

    rstn = 0; vga_vs = 1; pixel_xpos = '0; pixel_ypos = '0; src_data = '0;
    cfg_addr = '0; cfg_wdata = '0;
    set_idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_pixel", {16'b0, pixel_data}, 32'h0);
    check_output("rst_ready", {31'b0, src_ready}, 32'h0);
    check_output("rst_sof", {31'b0, src_sof}, 32'h0);
    read_check("rst_status", 15, 16'h0000);
    read_check("rst_uf_color", 11, 16'hF800);
    rstn = 1;

    // Background only
    cfg_write(0, 16'h07E0);
    commit_pulse();
    frame();
    req_pixel(0, 0, 1, 16'h1111);
    check_output("bg_a", {16'b0, pixel_data}, 32'h07E0);
    req_pixel(100, 3, 1, 16'h1111);
    check_output("bg_b", {16'b0, pixel_data}, 32'h07E0);
    read_check("frame_cnt_1", 15, 16'h0001);

    // Window 0 edges
    cfg_write(1, 10); cfg_write(2, 5); cfg_write(3, 20); cfg_write(4, 6);
    cfg_write(5, 16'h001F); cfg_write(10, 16'h0001);
    commit_pulse();
    frame();
    vecs[0] = '{1'b1,  9, 5, 16'h07E0, 1'b0};
    vecs[1] = '{1'b1, 10, 5, 16'h001F, 1'b0};
    vecs[2] = '{1'b1, 19, 5, 16'h001F, 1'b0};
    vecs[3] = '{1'b1, 20, 5, 16'h07E0, 1'b0};
    vecs[4] = '{1'b1, 15, 4, 16'h07E0, 1'b0};
    vecs[5] = '{1'b1, 15, 6, 16'h07E0, 1'b0};
    vecs[6] = '{1'b0, 15, 5, 16'h0000, 1'b0};
    for (int i = 0; i < 7; i++) begin
      data_req = vecs[i].req; pixel_xpos = CW'(vecs[i].x); pixel_ypos = CW'(vecs[i].y);
      src_valid = 1;
      apply_stimulus();
      check_output($sformatf("vec%0d_pix", i), {16'b0, pixel_data}, {16'b0, vecs[i].exp_pix});
      check_output($sformatf("vec%0d_ready", i), {31'b0, last_ready}, {31'b0, vecs[i].exp_ready});
    end
    set_idle();

    // Window 1 overlapping window 0, continuous stream
    cfg_write(6, 15); cfg_write(7, 5); cfg_write(8, 25); cfg_write(9, 7); cfg_write(10, 3);
    commit_pulse();
    frame();
    cnt = 0; sdata = 16'h0100;
    for (int y = 4; y <= 7; y++)
      for (int x = 5; x <= 29; x++) begin
        data_req = 1; pixel_xpos = CW'(x); pixel_ypos = CW'(y); src_valid = 1; src_data = sdata;
        apply_stimulus();
        if (last_ready === 1'b1) cnt++;
        sdata++;
      end
    set_idle();
    check_output("ready_area", cnt, 20);
    req_pixel(17, 5, 1, 16'hBEEF);
    check_output("overlap_stream", {16'b0, pixel_data}, 32'hBEEF);
    sof_base = sof_seen;
    frame();
    check_output("sof_once", sof_seen - sof_base, 1);

    // Underflow
    for (int x = 16; x <= 18; x++) begin
      req_pixel(x, 6, 0, 16'h2222);
      check_output("underflow_pix", {16'b0, pixel_data}, 32'hF800);
    end
    cfg_addr = 4'd15; #1;
    check_output("uf_sticky_set", {31'b0, cfg_rdata[15]}, 32'h1);
    cfg_write(15, 16'h0000);
    cfg_addr = 4'd15; #1;
    check_output("uf_sticky_clr", {31'b0, cfg_rdata[15]}, 32'h0);

    // Commit timing
    cfg_wr = 1; cfg_addr = 4'd0; cfg_wdata = 16'h1234; cfg_commit = 1;
    apply_stimulus();
    set_idle();
    req_pixel(0, 0, 1, 16'h0);
    check_output("commit_hold", {16'b0, pixel_data}, 32'h07E0);
    frame();
    req_pixel(0, 0, 1, 16'h0);
    check_output("commit_apply", {16'b0, pixel_data}, 32'h1234);
    cfg_write(0, 16'hABCD);
    vga_vs = 0; cfg_wr = 1; cfg_addr = 4'd0; cfg_wdata = 16'h5555; cfg_commit = 1;
    apply_stimulus();
    set_idle(); vga_vs = 1;
    apply_stimulus();
    req_pixel(0, 0, 1, 16'h0);
    check_output("bnd_write_old", {16'b0, pixel_data}, 32'hABCD);
    read_check("bnd_write_stage", 0, 16'h5555);

    // Empty window 1 (x1 == x0)
    cfg_write(8, 15);
    commit_pulse();
    frame();
    cnt = 0;
    for (int x = 10; x <= 30; x++) begin
      data_req = 1; pixel_xpos = CW'(x); pixel_ypos = 5; src_valid = 1;
      apply_stimulus();
      if (last_ready === 1'b1) cnt++;
    end
    set_idle();
    check_output("empty_window", cnt, 0);

    // Reset mid-line
    data_req = 1; pixel_xpos = 0; pixel_ypos = 0;
    apply_stimulus();
    rstn = 0;
    #1;
    check_output("midline_pixel", {16'b0, pixel_data}, 32'h0);
    check_output("midline_sof", {31'b0, src_sof}, 32'h0);
    read_check("midline_stage", 0, 16'h0000);
    set_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1;

    // Frame counter wrap
    sof_base = sof_seen;
    for (int i = 0; i < 255; i++) frame();
    read_check("fc_255", 15, 16'h00FF);
    frame();
    read_check("fc_wrap", 15, 16'h0000);
    check_output("sof_count", sof_seen - sof_base, 256);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      int a;
      data_req   = ($urandom_range(0, 9) < 8);
      pixel_xpos = CW'($urandom_range(0, 40));
      pixel_ypos = CW'($urandom_range(0, 40));
      src_valid  = ($urandom_range(0, 99) < 85);
      src_data   = 16'($urandom);
      vga_vs     = ($urandom_range(0, 99) >= 3);
      cfg_commit = ($urandom_range(0, 99) < 5);
      cfg_wr     = ($urandom_range(0, 9) == 0);
      a          = $urandom_range(0, 15);
      cfg_addr   = 4'(a);
      if ((a >= 1 && a <= 4) || (a >= 6 && a <= 9)) cfg_wdata = 16'($urandom_range(0, 40));
      else cfg_wdata = 16'($urandom);
      apply_stimulus();
    end
    set_idle();
    vga_vs = 1;
    apply_stimulus();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_layer_ctrl.md
# vga_layer_ctrl

Pixel source scheduler for `vga_driver`. It answers each `data_req` with a 16-bit RGB565 `pixel_data` word, one clock later. The word is picked from three layers by fixed priority: a streamed window (highest), a solid-colour window, and a background colour (lowest). Software writes to a staging register bank, which is copied into the live (shadow) registers at the next vertical sync. A frame is therefore never drawn with half-updated settings.

## Interface
Parameters:
- `CW`, 11: coordinate width; must match the width of `pixel_xpos`/`pixel_ypos`.
- `UF_COLOR_RST`, 16'hF800: reset value of the underflow colour register.

Ports:
- `clk`  in  1  pixel clock, the same clock as `vga_driver`.
- `rstn`  in  1  reset; asynchronous, active-low.
- `data_req`  in  1  pixel request from `vga_driver`.
- `pixel_xpos`  in  CW  current x coordinate; valid while `data_req` is high.
- `pixel_ypos`  in  CW  current y coordinate; valid while `data_req` is high.
- `vga_vs`  in  1  vertical sync; active-low pulse.
- `pixel_data`  out  16  pixel word returned to `vga_driver`; registered.
- `src_data`  in  16  stream pixel for window 1.
- `src_valid`  in  1  `src_data` is valid.
- `src_ready`  out  1  stream pixel is consumed this cycle; combinational.
- `src_sof`  out  1  one-cycle pulse at the frame boundary.
- `cfg_wr`  in  1  write strobe.
- `cfg_addr`  in  4  register address.
- `cfg_wdata`  in  16  write data.
- `cfg_rdata`  out  16  read data; combinational from `cfg_addr`.
- `cfg_commit`  in  1  request a staging-to-shadow copy at the next frame boundary.

## Operation
Register map (staging registers; every reset value is 0 unless stated):
- 0: `bg_color`.
- 1–4: `w0_x0`, `w0_y0`, `w0_x1`, `w0_y1`. Only the low CW bits are used.
- 5: `w0_color`.
- 6–9: `w1_x0`, `w1_y0`, `w1_x1`, `w1_y1`.
- 10: `ctrl`. Bit 0 = `w0_en`, bit 1 = `w1_en`.
- 11: `uf_color`. Reset value is `UF_COLOR_RST`.
- 15 (read-only): `{uf_sticky, pending, 6'b0, frame_cnt[7:0]}`. Any write to address 15 clears `uf_sticky`.
- Addresses 12–14 read as 0; writes to them are ignored.

Register behaviour:
- Reads always return the staging value.
- The shadow registers reset to the same values as staging.

Frame boundary:
- The boundary is the first cycle in which `vga_vs` is sampled 0 after being sampled 1 (a registered edge detect).
- At the boundary:
  - `src_sof` pulses.
  - `frame_cnt` increments, wrapping 255 → 0.
  - If `pending` is set, or `cfg_commit` is high in that same cycle, all staging registers are copied into shadow and `pending` clears.
- Outside the boundary, `cfg_commit` sets `pending`.
- If `cfg_wr` falls in the boundary cycle, the write lands in staging and shadow receives the value from before the write.

Window membership (uses shadow values):
- A pixel is in window n when `wn_en` is set, `xn0 <= x < xn1`, and `yn0 <= y < yn1`. The comparisons are unsigned.
- If `x1 <= x0` or `y1 <= y0`, the window is empty.

Pixel selection in a cycle with `data_req` = 1:
- In window 1: `src_ready` = 1.
  - If `src_valid` = 1, the next `pixel_data` is `src_data`.
  - Otherwise, the next `pixel_data` is `uf_color` and `uf_sticky` is set.
- Otherwise, in window 0: the next `pixel_data` is `w0_color`.
- Otherwise: the next `pixel_data` is `bg_color`.

When `data_req` = 0:
- The next `pixel_data` is 16'h0000.
- `src_ready` = 0.

## Timing
- Reset values: `pixel_data` = 0, `src_ready` = 0, `src_sof` = 0, `frame_cnt` = 0, `pending` = 0, `uf_sticky` = 0. The edge-detect register resets to 1, so a low `vga_vs` at release is not counted as a boundary.
- Latency: `pixel_data` is valid exactly 1 cycle after the `data_req` cycle it answers. Throughput is one pixel per cycle.
- `src_ready` is combinational from `data_req`, the coordinates, and the shadow registers. A stream beat is consumed only when `src_valid` and `src_ready` are both high.
- `cfg_wr` takes effect at the clock edge; `cfg_rdata` shows the new value in the following cycle.
- Asserting reset mid-frame immediately forces all outputs and registers to their reset values. After release, the first boundary is the next falling edge of `vga_vs`.

## Test plan
- Reset release, background only: write `bg_color` = 16'h07E0, pulse `cfg_commit`, wait for one `vga_vs` fall. Every pixel must be 16'h07E0, one cycle after its `data_req`; `frame_cnt` reads 1.
- Window 0 edges: x0 = 10, x1 = 20, y0 = 5, y1 = 6, `w0_color` = 16'h001F, `w0_en` = 1. x = 9 gives bg, x = 10 gives 16'h001F, x = 19 gives 16'h001F, x = 20 gives bg. Only line y = 5 is affected.
- Priority and stream: set window 1 to overlap window 0 and hold `src_valid` = 1 with an incrementing `src_data`. Inside the overlap, the output is the stream. `src_ready` is high exactly the window-1 area times the request cycles, and `src_sof` pulses once per frame.
- Underflow: drop `src_valid` for 3 pixels inside window 1. Those 3 pixels must be 16'hF800 and `uf_sticky` = 1. A write to address 15 must clear it.
- Commit timing: update `bg_color` in staging mid-frame with `cfg_commit`. The output is unchanged until the boundary, then shows the new value. A commit and a write in the boundary cycle must leave shadow with the old value.
- Edge cases: the empty window x1 = x0 never selects that window. `frame_cnt` wraps 255 → 0. Asserting `rstn` low mid-line must zero `pixel_data` immediately.
